sr_debug_dump: RTL and testbench

Debug-port reader for the schoolRISCV core. It drives the core's debug register address, samples the returned debug data and streams a snapshot of a register range out over a valid/ready interface, one word per beat, tagged with the register index. It sits beside `sr_cpu` in the top-level and lets a bench, UART bridge or logic analyser dump CPU state without stopping the core.

---
 rtl/sr_debug_pkg.sv | 7 +
 rtl/sr_dump_out_reg.sv | 41 ++++
 rtl/sr_debug_dump.sv | 122 ++++++++++++
 tb/tb_sr_debug_dump.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sr_debug_pkg.sv
// sr_debug_pkg: dump FSM state encoding and the fixed debug addresses of the schoolRISCV core.
// The pc sits at debug address 0. The sticky overflow flag sits at debug address 31.
package sr_debug_pkg;
    typedef enum logic [1:0] {IDLE, READ, SEND, FIN} dump_state_t;
    localparam logic [4:0] SR_DBG_PC_ADDR = 5'd0;
    localparam logic [4:0] SR_DBG_OV_ADDR = 5'd31;
endpackage

// File: rtl/sr_dump_out_reg.sv
// sr_dump_out_reg: output holding register for one dump beat.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   i_load            - capture i_data/i_idx/i_last/i_sum and raise o_valid
//   i_ready           - sink ready; o_valid drops after a handshake
//   o_valid, o_data, o_idx, o_last, o_sum - registered beat, held until accepted
module sr_dump_out_reg
    import sr_debug_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_ready,
    input  logic [31:0] i_data,
    input  logic [4:0]  i_idx,
    input  logic        i_last,
    input  logic        i_sum,
    output logic        o_valid,
    output logic [31:0] o_data,
    output logic [4:0]  o_idx,
    output logic        o_last,
    output logic        o_sum
);
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_idx   <= SR_DBG_PC_ADDR;
            o_last  <= 1'b0;
            o_sum   <= 1'b0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
            o_idx   <= i_idx;
            o_last  <= i_last;
            o_sum   <= i_sum;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/sr_debug_dump.sv
// sr_debug_dump: streams debug registers FIRST_REG..LAST_REG of the core out over a valid/ready port.
// Optional feature macro: SR_DEBUG_DUMP_SUM_EN appends a mod-2^32 checksum beat and adds port outSum.
// Ports:
//   clk, rst            - core clock and synchronous active-high reset
//   start               - one-cycle dump request. It is ignored while a dump runs.
//   busy, done          - dump in progress; one-cycle pulse after the final beat is accepted
//   regAddr, regData    - debug register address to the core and its combinational read data
//   outValid, outReady  - beat handshake
//   outData, outIdx     - beat payload and the debug address it came from
//   outLast, outSum     - final-beat marker; checksum-beat marker (only with SR_DEBUG_DUMP_SUM_EN)
module sr_debug_dump
    import sr_debug_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] outData,
    output logic [4:0]  outIdx,
    output logic        outLast
`ifdef SR_DEBUG_DUMP_SUM_EN
    ,
    output logic        outSum
`endif
);
    localparam logic [4:0] FIRST = 5'(FIRST_REG);
    localparam logic [4:0] LAST  = 5'(LAST_REG);

    dump_state_t r_state, w_next;
    logic [4:0]  r_idx;
    logic        w_load, w_hs, w_final, w_out_sum, w_sum_beat, w_ld_last;
    logic [31:0] w_ld_data;
    logic [4:0]  w_ld_idx;

    assign w_hs    = outValid && outReady;
    // The checksum beat is always flagged last, so this covers both builds.
    assign w_final = outLast || w_out_sum;
    assign regAddr = r_idx;
    assign busy    = (r_state == READ) || (r_state == SEND);
    assign done    = r_state == FIN;

`ifdef SR_DEBUG_DUMP_SUM_EN
    // r_phase marks the extra READ that emits the checksum instead of a register.
    logic        r_phase;
    logic [31:0] r_sum;
    assign w_sum_beat = r_phase;
    assign w_ld_data  = r_phase ? r_sum : regData;
    assign w_ld_idx   = r_phase ? SR_DBG_PC_ADDR : r_idx;
    assign w_ld_last  = r_phase;
    assign outSum     = w_out_sum;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= 1'b0;
            r_sum   <= '0;
        end else if (r_state == IDLE && start) begin
            r_phase <= 1'b0;
            r_sum   <= '0;
        end else begin
            if (r_state == READ && !r_phase)
                r_sum <= r_sum + regData;
            if (r_state == SEND && w_hs && !w_final && r_idx == LAST)
                r_phase <= 1'b1;
        end
    end
`else
    assign w_sum_beat = 1'b0;
    assign w_ld_data  = regData;
    assign w_ld_idx   = r_idx;
    assign w_ld_last  = r_idx == LAST;
`endif

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            IDLE:    w_next = start ? READ : IDLE;
            READ: begin
                w_load = 1'b1;
                w_next = SEND;
            end
            SEND:    w_next = w_hs ? (w_final ? FIN : READ) : SEND;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= SR_DBG_PC_ADDR;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start)
                r_idx <= FIRST;
            else if (r_state == SEND && w_hs && !w_final && r_idx != LAST)
                r_idx <= r_idx + 5'd1;
        end
    end

    sr_dump_out_reg u_out (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_ready (outReady),
        .i_data  (w_ld_data),
        .i_idx   (w_ld_idx),
        .i_last  (w_ld_last),
        .i_sum   (w_sum_beat),
        .o_valid (outValid),
        .o_data  (outData),
        .o_idx   (outIdx),
        .o_last  (outLast),
        .o_sum   (w_out_sum)
    );
endmodule

// File: tb/tb_sr_debug_dump.sv
// tb_sr_debug_dump: randomized and directed dumps checked against a queue-based model of the expected beat stream.
module tb_sr_debug_dump;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0]       st, rdy, busy, done, val, lst;
    logic [2:0][4:0]  addr, oidx;
    logic [2:0][31:0] rdat, odat;
`ifdef SR_DEBUG_DUMP_SUM_EN
    logic [2:0] osum;
    localparam bit SUM = 1'b1;
`else
    localparam bit SUM = 1'b0;
`endif
    logic [31:0] regs [32];
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  idx;
        logic        last;
        logic        sm;
    } beat_t;

    always #5 clk = ~clk;

    assign rdat[0] = regs[addr[0]];
    assign rdat[1] = regs[addr[1]];
    assign rdat[2] = regs[addr[2]];

    sr_debug_dump d0 (
        .clk(clk), .rst(rst), .start(st[0]), .busy(busy[0]), .done(done[0]),
        .regAddr(addr[0]), .regData(rdat[0]), .outValid(val[0]), .outReady(rdy[0]),
        .outData(odat[0]), .outIdx(oidx[0]), .outLast(lst[0])
`ifdef SR_DEBUG_DUMP_SUM_EN
        , .outSum(osum[0])
`endif
    );
    sr_debug_dump #(.FIRST_REG(5), .LAST_REG(7)) d1 (
        .clk(clk), .rst(rst), .start(st[1]), .busy(busy[1]), .done(done[1]),
        .regAddr(addr[1]), .regData(rdat[1]), .outValid(val[1]), .outReady(rdy[1]),
        .outData(odat[1]), .outIdx(oidx[1]), .outLast(lst[1])
`ifdef SR_DEBUG_DUMP_SUM_EN
        , .outSum(osum[1])
`endif
    );
    sr_debug_dump #(.FIRST_REG(1), .LAST_REG(3)) d2 (
        .clk(clk), .rst(rst), .start(st[2]), .busy(busy[2]), .done(done[2]),
        .regAddr(addr[2]), .regData(rdat[2]), .outValid(val[2]), .outReady(rdy[2]),
        .outData(odat[2]), .outIdx(oidx[2]), .outLast(lst[2])
`ifdef SR_DEBUG_DUMP_SUM_EN
        , .outSum(osum[2])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready held high, 1: ready low for 5 cycles on beat stall_idx, 2: random ready.
    // restart_beat >= 0 pulses a second start while that beat is on the port.
    task automatic dump(input int d, input int first, input int lastr, input int mode,
                        input int stall_idx, input int restart_beat);
        beat_t q[$];
        beat_t b;
        logic [31:0] s = '0;
        int c = 0, stall = 5, beats = 0, ndone = 0, exp_cyc;
        bit pulsed = 1'b0;
        for (int i = first; i <= lastr; i++) begin
            q.push_back('{regs[i], 5'(i), !SUM && i == lastr, 1'b0});
            s += regs[i];
        end
        if (SUM) q.push_back('{s, 5'd0, 1'b1, 1'b1});
        exp_cyc = 2 * q.size() + 1;
        @(negedge clk);
        chk("idle_busy", 32'(busy[d]), 0);
        st[d] = 1'b1;
        while (c < 600 && ndone == 0) begin
            @(negedge clk);
            c++;
            st[d] = 1'b0;
            if (mode == 0) rdy[d] = 1'b1;
            else if (mode == 1) begin
                rdy[d] = !(val[d] && int'(oidx[d]) == stall_idx && stall > 0);
                if (!rdy[d]) stall--;
            end else rdy[d] = 1'($urandom_range(0, 1));
            if (restart_beat >= 0 && !pulsed && val[d] && beats == restart_beat) begin
                st[d] = 1'b1;
                pulsed = 1'b1;
            end
            if (!val[d] && busy[d] && q.size() > 0)
                chk("regaddr", 32'(addr[d]), q[0].sm ? 32'(lastr) : 32'(q[0].idx));
            if (val[d]) begin
                chk("beat_expected", 32'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    b = q[0];
                    chk("data", odat[d], b.data);
                    chk("idx", 32'(oidx[d]), 32'(b.idx));
                    chk("last", 32'(lst[d]), 32'(b.last));
`ifdef SR_DEBUG_DUMP_SUM_EN
                    chk("sum_flag", 32'(osum[d]), 32'(b.sm));
`endif
                    chk("busy_send", 32'(busy[d]), 1);
                    if (rdy[d]) begin
                        void'(q.pop_front());
                        beats++;
                    end
                end
            end
            if (done[d]) begin
                ndone++;
                chk("done_all_beats", q.size(), 0);
                if (mode == 0) chk("done_cycle", c, exp_cyc);
            end
        end
        chk("done_seen", ndone, 1);
        repeat (4) begin
            @(negedge clk);
            chk("no_extra_done", 32'(done[d]), 0);
            chk("back_idle", 32'(busy[d]), 0);
        end
    endtask

    initial begin
        int n;
        st = '0;
        rdy = '0;
        regs[0] = 32'h40;
        for (int i = 1; i < 31; i++) regs[i] = 32'(i * 16);
        regs[31] = 32'h1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy[0]), 0);
        chk("rst_done", 32'(done[0]), 0);
        chk("rst_valid", 32'(val[0]), 0);
        chk("rst_last", 32'(lst[0]), 0);
        chk("rst_data", odat[0], 0);
        chk("rst_idx", 32'(oidx[0]), 0);
        chk("rst_addr", 32'(addr[0]), 0);
`ifdef SR_DEBUG_DUMP_SUM_EN
        chk("rst_sum", 32'(osum[0]), 0);
`endif
        rst = 1'b0;
        dump(0, 0, 31, 0, -1, -1);
        dump(0, 0, 31, 1, 3, -1);
        dump(1, 5, 7, 0, -1, -1);
        dump(0, 0, 31, 0, -1, 10);
        @(negedge clk);
        rdy[0] = 1'b1;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        n = 0;
        while (!(val[0] && oidx[0] == 5'd12) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_idx12", 32'(oidx[0]), 12);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_valid", 32'(val[0]), 0);
        chk("abort_busy", 32'(busy[0]), 0);
        chk("abort_addr", 32'(addr[0]), 0);
        chk("abort_done", 32'(done[0]), 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done[0]), 0);
            chk("abort_no_valid", 32'(val[0]), 0);
        end
        dump(0, 0, 31, 0, -1, -1);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            dump(0, 0, 31, 2, -1, -1);
            dump(1, 5, 7, 2, -1, -1);
            dump(2, 1, 3, 2, -1, -1);
        end
        regs[1] = 32'hFFFF_FFFF;
        regs[2] = 32'h2;
        regs[3] = 32'h3;
        dump(2, 1, 3, 0, -1, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
